ex_mem_stage: RTL and testbench

//  EX stage plus EX/MEM pipeline register, directly upstream of MEM_WB. Runs the ALU, computes load/store

---
 rtl/ex_pkg.sv | 59 +++++
 rtl/ex_mem_stage_alu.sv | 48 ++++
 rtl/ex_mem_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ----------------------------------------------------------------------------
// ex_pkg
// Shared encodings for the execute stage: ALU operation codes, branch funct3
// codes and load/store sub-op codes. The decoder, ex_mem_stage and MEM_WB all
// import this package so the encodings stay in one place.
// Also provides is_misaligned(), the alignment rule shared by loads and stores.
// ----------------------------------------------------------------------------
package ex_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_op_e;

    typedef enum logic [2:0] {
        SUB_LB  = 3'b000,
        SUB_LH  = 3'b001,
        SUB_LW  = 3'b010,
        SUB_LBU = 3'b011,
        SUB_LHU = 3'b100,
        SUB_SB  = 3'b101,
        SUB_SH  = 3'b110,
        SUB_SW  = 3'b111
    } sub_op_e;

    // Halfword accesses need addr[0]==0, word accesses need addr[1:0]==0.
    function automatic logic is_misaligned(input logic [2:0] sub_op, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (sub_op_e'(sub_op))
            SUB_LH, SUB_LHU, SUB_SH: mis = addr_lo[0];
            SUB_LW, SUB_SW:          mis = (addr_lo != 2'b00);
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ex_mem_stage_alu.sv
// ----------------------------------------------------------------------------
// ex_alu
// Purely combinational ALU for the execute stage. All results are mod 2^XLEN;
// shift amounts come from b[4:0]. LUI passes b through, AUIPC returns pc + b
// (the decoder selects the immediate as b for both).
// Ports:
//   op     in  4     ALU op (ex_pkg::alu_op_e codes)
//   a      in  XLEN  operand A (rs1 value)
//   b      in  XLEN  operand B (rs2 value or immediate)
//   pc     in  XLEN  PC of the instruction, for AUIPC
//   result out XLEN  ALU result
// ----------------------------------------------------------------------------
module ex_alu
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        result = '0;
        case (alu_op_e'(op))
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_LUI:   result = b;
            ALU_AUIPC: result = pc + b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
// Execute stage plus EX/MEM pipeline register. Runs the ALU, forms load/store
// addresses, resolves branches and jumps (combinational redirect), and
// registers the result, rd, write enable, sub-op, store data and type flags
// for MEM_WB. Misaligned halfword/word accesses are squashed into a bubble and
// reported by a one-cycle misalign pulse.
//
// Build option: define EX_FWD_EN to forward MEM_WB results into rs1/rs2
// (MEM combinational data first, then WB registered data). Without it the raw
// rv1_in/rv2_in values are used and the forwarding ports are ignored.
//
// Ports:
//   clk, reset (sync, active-high)
//   pc_in, rv1_in, rv2_in, imm_in, rs1_in, rs2_in   operands from ID/EX
//   alu_op_in, use_imm_in, br_op_in                 ALU / branch controls
//   is_branch_in, is_jal_in, is_jalr_in             control-flow type
//   sub_op_in, rd_in, rwe_in, is_load_in, is_store_in, is_nop_in
//   stall_in                                        hold all state
//   mem_fwd_data/rwe, wb_data/rd/rwe                forwarding sources
//   daddr, reg_wdata_out, r_rv2_out, rd_out, sub_op_out,
//   rwe_out, is_load_out, is_store_out, is_nop_out  registered to MEM_WB
//   redirect, redirect_pc                           combinational to fetch
//   misalign                                        registered squash pulse
// ----------------------------------------------------------------------------
module ex_mem_stage
    import ex_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0   // fetch-side only, no effect here
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rv1_in,
    input  logic [XLEN-1:0] rv2_in,
    input  logic [4:0]      rs1_in,
    input  logic [4:0]      rs2_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [3:0]      alu_op_in,
    input  logic            use_imm_in,
    input  logic [2:0]      br_op_in,
    input  logic            is_branch_in,
    input  logic            is_jal_in,
    input  logic            is_jalr_in,
    input  logic [2:0]      sub_op_in,
    input  logic [4:0]      rd_in,
    input  logic            rwe_in,
    input  logic            is_load_in,
    input  logic            is_store_in,
    input  logic            is_nop_in,
    input  logic            stall_in,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            mem_fwd_rwe,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      wb_rd,
    input  logic            wb_rwe,
    output logic [XLEN-1:0] daddr,
    output logic [XLEN-1:0] reg_wdata_out,
    output logic [XLEN-1:0] r_rv2_out,
    output logic [4:0]      rd_out,
    output logic [2:0]      sub_op_out,
    output logic            rwe_out,
    output logic            is_load_out,
    output logic            is_store_out,
    output logic            is_nop_out,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            misalign
);

    logic [XLEN-1:0] daddr_q, daddr_d;
    logic [XLEN-1:0] reg_wdata_q, reg_wdata_d;
    logic [XLEN-1:0] r_rv2_q, r_rv2_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      sub_op_q, sub_op_d;
    logic            rwe_q, rwe_d;
    logic            is_load_q, is_load_d;
    logic            is_store_q, is_store_d;
    logic            is_nop_q, is_nop_d;
    logic            misalign_q, misalign_d;

    logic            unused_cfg;
    assign unused_cfg = ^RESET_PC;

    // ---------------- operand selection ----------------
    logic [XLEN-1:0] op_a, op_rv2, op_b;

`ifdef EX_FWD_EN
    // rd_q == rs implies rs != 0 once rs != 0 is checked; the MEM source is newer than WB.
    always_comb begin
        op_a = rv1_in;
        if (rs1_in != 5'd0 && rs1_in == rd_q && mem_fwd_rwe && !is_nop_q)
            op_a = mem_fwd_data;
        else if (rs1_in != 5'd0 && rs1_in == wb_rd && wb_rwe)
            op_a = wb_data;

        op_rv2 = rv2_in;
        if (rs2_in != 5'd0 && rs2_in == rd_q && mem_fwd_rwe && !is_nop_q)
            op_rv2 = mem_fwd_data;
        else if (rs2_in != 5'd0 && rs2_in == wb_rd && wb_rwe)
            op_rv2 = wb_data;
    end
`else
    assign op_a   = rv1_in;
    assign op_rv2 = rv2_in;

    logic unused_fwd;
    assign unused_fwd = ^{rs1_in, rs2_in, mem_fwd_data, mem_fwd_rwe, wb_data, wb_rd, wb_rwe};
`endif

    assign op_b = use_imm_in ? imm_in : op_rv2;

    // ---------------- ALU ----------------
    logic [XLEN-1:0] alu_result;

    ex_alu #(.XLEN(XLEN)) u_alu (
        .op     (alu_op_in),
        .a      (op_a),
        .b      (op_b),
        .pc     (pc_in),
        .result (alu_result)
    );

    // ---------------- branch resolution ----------------
    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        case (br_op_e'(br_op_in))
            BR_BEQ:  br_taken = (op_a == op_rv2);
            BR_BNE:  br_taken = (op_a != op_rv2);
            BR_BLT:  br_taken = ($signed(op_a) <  $signed(op_rv2));
            BR_BGE:  br_taken = ($signed(op_a) >= $signed(op_rv2));
            BR_BLTU: br_taken = (op_a <  op_rv2);
            BR_BGEU: br_taken = (op_a >= op_rv2);
            default: br_taken = 1'b0;
        endcase
    end

    // Shared by load/store address and the JALR target.
    logic [XLEN-1:0] addr_sum;
    assign addr_sum = op_a + imm_in;

    assign redirect    = ((is_branch_in & br_taken) | is_jal_in | is_jalr_in)
                         & ~is_nop_in & ~stall_in & ~reset;
    assign redirect_pc = is_jalr_in ? {addr_sum[XLEN-1:1], 1'b0} : (pc_in + imm_in);

    // ---------------- squash decision ----------------
    logic mis_acc, bubble;
    assign mis_acc = (is_load_in | is_store_in) & ~is_nop_in
                     & is_misaligned(sub_op_in, addr_sum[1:0]);
    assign bubble  = is_nop_in | mis_acc;

    // ---------------- next state ----------------
    always_comb begin
        daddr_d     = daddr_q;
        reg_wdata_d = reg_wdata_q;
        r_rv2_d     = r_rv2_q;
        rd_d        = rd_q;
        sub_op_d    = sub_op_q;
        rwe_d       = rwe_q;
        is_load_d   = is_load_q;
        is_store_d  = is_store_q;
        is_nop_d    = is_nop_q;
        misalign_d  = 1'b0;     // a pulse: cleared on stall as well
        if (!stall_in) begin
            daddr_d     = addr_sum;
            reg_wdata_d = (is_jal_in | is_jalr_in) ? (pc_in + XLEN'(4)) : alu_result;
            r_rv2_d     = op_rv2;
            sub_op_d    = sub_op_in;
            rd_d        = bubble ? 5'd0 : rd_in;
            rwe_d       = ~bubble & rwe_in & (rd_in != 5'd0);
            is_load_d   = ~bubble & is_load_in;
            is_store_d  = ~bubble & is_store_in;
            is_nop_d    = bubble;
            misalign_d  = mis_acc;
        end
    end

    // ---------------- EX/MEM register ----------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            daddr_q     <= '0;
            reg_wdata_q <= '0;
            r_rv2_q     <= '0;
            rd_q        <= '0;
            sub_op_q    <= '0;
            rwe_q       <= 1'b0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            is_nop_q    <= 1'b1;
            misalign_q  <= 1'b0;
        end else begin
            daddr_q     <= daddr_d;
            reg_wdata_q <= reg_wdata_d;
            r_rv2_q     <= r_rv2_d;
            rd_q        <= rd_d;
            sub_op_q    <= sub_op_d;
            rwe_q       <= rwe_d;
            is_load_q   <= is_load_d;
            is_store_q  <= is_store_d;
            is_nop_q    <= is_nop_d;
            misalign_q  <= misalign_d;
        end
    end

    assign daddr         = daddr_q;
    assign reg_wdata_out = reg_wdata_q;
    assign r_rv2_out     = r_rv2_q;
    assign rd_out        = rd_q;
    assign sub_op_out    = sub_op_q;
    assign rwe_out       = rwe_q;
    assign is_load_out   = is_load_q;
    assign is_store_out  = is_store_q;
    assign is_nop_out    = is_nop_q;
    assign misalign      = misalign_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_stage
// Directed scenarios followed by random instructions checked against a
// behavioural model of the execute stage. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled away from the edge.
// ----------------------------------------------------------------------------
module tb_ex_mem_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, rv1_in, rv2_in, imm_in;
    logic [4:0]  rs1_in, rs2_in, rd_in;
    logic [3:0]  alu_op_in;
    logic        use_imm_in;
    logic [2:0]  br_op_in, sub_op_in;
    logic        is_branch_in, is_jal_in, is_jalr_in;
    logic        rwe_in, is_load_in, is_store_in, is_nop_in, stall_in;
    logic [31:0] mem_fwd_data, wb_data;
    logic        mem_fwd_rwe, wb_rwe;
    logic [4:0]  wb_rd;
    logic [31:0] daddr, reg_wdata_out, r_rv2_out, redirect_pc;
    logic [4:0]  rd_out;
    logic [2:0]  sub_op_out;
    logic        rwe_out, is_load_out, is_store_out, is_nop_out, redirect, misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .rv1_in(rv1_in), .rv2_in(rv2_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in), .alu_op_in(alu_op_in),
        .use_imm_in(use_imm_in), .br_op_in(br_op_in), .is_branch_in(is_branch_in),
        .is_jal_in(is_jal_in), .is_jalr_in(is_jalr_in), .sub_op_in(sub_op_in),
        .rd_in(rd_in), .rwe_in(rwe_in), .is_load_in(is_load_in), .is_store_in(is_store_in),
        .is_nop_in(is_nop_in), .stall_in(stall_in), .mem_fwd_data(mem_fwd_data),
        .mem_fwd_rwe(mem_fwd_rwe), .wb_data(wb_data), .wb_rd(wb_rd), .wb_rwe(wb_rwe),
        .daddr(daddr), .reg_wdata_out(reg_wdata_out), .r_rv2_out(r_rv2_out),
        .rd_out(rd_out), .sub_op_out(sub_op_out), .rwe_out(rwe_out),
        .is_load_out(is_load_out), .is_store_out(is_store_out), .is_nop_out(is_nop_out),
        .redirect(redirect), .redirect_pc(redirect_pc), .misalign(misalign)
    );

    typedef struct {
        logic [31:0] pc, rv1, rv2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu_op;
        logic        use_imm;
        logic [2:0]  br_op, sub_op;
        logic        br, jal, jalr, rwe, ld, st, nop;
    } instr_t;

    typedef struct {
        logic [31:0] daddr, wdata, rv2, rpc;
        logic [4:0]  rd;
        logic [2:0]  sub_op;
        logic        rwe, ld, st, nop, mis, redirect;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t idle_instr();
        instr_t t;
        t = '{pc: 32'h0, rv1: 32'h0, rv2: 32'h0, imm: 32'h0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
              alu_op: 4'd0, use_imm: 1'b0, br_op: 3'd0, sub_op: 3'd0,
              br: 1'b0, jal: 1'b0, jalr: 1'b0, rwe: 1'b0, ld: 1'b0, st: 1'b0, nop: 1'b1};
        return t;
    endfunction

    function automatic instr_t live_instr();
        instr_t t;
        t = idle_instr();
        t.nop = 1'b0;
        return t;
    endfunction

    task automatic apply(input instr_t t);
        pc_in = t.pc; rv1_in = t.rv1; rv2_in = t.rv2; imm_in = t.imm;
        rs1_in = t.rs1; rs2_in = t.rs2; rd_in = t.rd;
        alu_op_in = t.alu_op; use_imm_in = t.use_imm; br_op_in = t.br_op; sub_op_in = t.sub_op;
        is_branch_in = t.br; is_jal_in = t.jal; is_jalr_in = t.jalr;
        rwe_in = t.rwe; is_load_in = t.ld; is_store_in = t.st; is_nop_in = t.nop;
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e = '{daddr: 32'h0, wdata: 32'h0, rv2: 32'h0, rpc: 32'h0, rd: 5'd0, sub_op: 3'd0,
              rwe: 1'b0, ld: 1'b0, st: 1'b0, nop: 1'b1, mis: 1'b0, redirect: 1'b0};
        return e;
    endfunction

    // Reference behaviour of one instruction (no forwarding, no stall).
    function automatic exp_t model(input instr_t t);
        exp_t        e;
        logic [31:0] b, res, addr;
        logic        taken, mis, bub;
        b = t.use_imm ? t.imm : t.rv2;
        case (alu_op_e'(t.alu_op))
            ALU_ADD:   res = t.rv1 + b;
            ALU_SUB:   res = t.rv1 - b;
            ALU_SLL:   res = t.rv1 << b[4:0];
            ALU_SLT:   res = ($signed(t.rv1) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:  res = (t.rv1 < b) ? 32'd1 : 32'd0;
            ALU_XOR:   res = t.rv1 ^ b;
            ALU_SRL:   res = t.rv1 >> b[4:0];
            ALU_SRA:   res = $unsigned($signed(t.rv1) >>> b[4:0]);
            ALU_OR:    res = t.rv1 | b;
            ALU_AND:   res = t.rv1 & b;
            ALU_LUI:   res = t.imm;
            ALU_AUIPC: res = t.pc + t.imm;
            default:   res = 32'h0;
        endcase
        case (t.br_op)
            3'b000:  taken = (t.rv1 == t.rv2);
            3'b001:  taken = (t.rv1 != t.rv2);
            3'b100:  taken = ($signed(t.rv1) <  $signed(t.rv2));
            3'b101:  taken = ($signed(t.rv1) >= $signed(t.rv2));
            3'b110:  taken = (t.rv1 <  t.rv2);
            3'b111:  taken = (t.rv1 >= t.rv2);
            default: taken = 1'b0;
        endcase
        addr = t.rv1 + t.imm;
        mis  = 1'b0;
        if ((t.ld || t.st) && !t.nop) begin
            case (t.sub_op)
                3'b001, 3'b100, 3'b110: mis = (addr % 2) != 0;
                3'b010, 3'b111:         mis = (addr % 4) != 0;
                default:                mis = 1'b0;
            endcase
        end
        bub        = t.nop || mis;
        e.daddr    = addr;
        e.wdata    = (t.jal || t.jalr) ? t.pc + 32'd4 : res;
        e.rv2      = t.rv2;
        e.sub_op   = t.sub_op;
        e.rd       = bub ? 5'd0 : t.rd;
        e.rwe      = !bub && t.rwe && (t.rd != 5'd0);
        e.ld       = !bub && t.ld;
        e.st       = !bub && t.st;
        e.nop      = bub;
        e.mis      = mis;
        e.redirect = !t.nop && ((t.br && taken) || t.jal || t.jalr);
        e.rpc      = t.jalr ? (addr & 32'hFFFF_FFFE) : t.pc + t.imm;
        return e;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t t;
        exp_t   e, q;
        logic   stl;
        int     kind;

        reset = 1'b1; stall_in = 1'b0;
        mem_fwd_data = 32'h0; mem_fwd_rwe = 1'b0; wb_data = 32'h0; wb_rd = 5'd0; wb_rwe = 1'b0;
        apply(idle_instr());
        tick(); tick();

        // ---- reset state; JAL presented during reset must not redirect ----
        t = live_instr(); t.jal = 1'b1; t.pc = 32'h10; t.imm = 32'h40; t.rd = 5'd1; t.rwe = 1'b1;
        apply(t);
        #1;
        check("reset_redirect", {31'd0, redirect}, 32'd0);
        check("reset_daddr", daddr, 32'h0);
        check("reset_wdata", reg_wdata_out, 32'h0);
        check("reset_rv2", r_rv2_out, 32'h0);
        check("reset_rd", {27'd0, rd_out}, 32'd0);
        check("reset_flags", {26'd0, sub_op_out, rwe_out, is_load_out, is_store_out}, 32'd0);
        check("reset_nop", {31'd0, is_nop_out}, 32'd1);
        check("reset_mis", {31'd0, misalign}, 32'd0);
        apply(idle_instr());
        tick();
        reset = 1'b0;

        // ---- ADD rv1=5, imm=-7 ----
        t = live_instr(); t.alu_op = ALU_ADD; t.rv1 = 32'd5; t.imm = 32'hFFFF_FFF9;
        t.use_imm = 1'b1; t.rd = 5'd3; t.rwe = 1'b1;
        apply(t);
        tick();
        check("add_wdata", reg_wdata_out, 32'hFFFF_FFFE);
        check("add_rwe", {31'd0, rwe_out}, 32'd1);
        check("add_rd", {27'd0, rd_out}, 32'd3);
        check("add_nop", {31'd0, is_nop_out}, 32'd0);

        // ---- rd=0 suppresses write enable ----
        t.rd = 5'd0;
        apply(t);
        tick();
        check("rd0_rwe", {31'd0, rwe_out}, 32'd0);

        // ---- misaligned LW: bubble plus one-cycle pulse ----
        t = live_instr(); t.ld = 1'b1; t.sub_op = SUB_LW; t.rv1 = 32'h100; t.imm = 32'd6;
        t.alu_op = ALU_ADD; t.use_imm = 1'b1; t.rd = 5'd4; t.rwe = 1'b1;
        apply(t);
        tick();
        check("mis_nop", {31'd0, is_nop_out}, 32'd1);
        check("mis_rwe", {31'd0, rwe_out}, 32'd0);
        check("mis_rd", {27'd0, rd_out}, 32'd0);
        check("mis_ld", {31'd0, is_load_out}, 32'd0);
        check("mis_pulse", {31'd0, misalign}, 32'd1);
        apply(idle_instr());
        tick();
        check("mis_pulse_end", {31'd0, misalign}, 32'd0);

        // ---- aligned LW and LH boundaries ----
        t.imm = 32'd4;
        apply(t);
        tick();
        check("lw_ok_ld", {31'd0, is_load_out}, 32'd1);
        check("lw_ok_daddr", daddr, 32'h104);
        t.sub_op = SUB_LH; t.imm = 32'd2;
        apply(t);
        tick();
        check("lh_ok_nop", {31'd0, is_nop_out}, 32'd0);
        t.imm = 32'd3;
        apply(t);
        tick();
        check("lh_mis_pulse", {31'd0, misalign}, 32'd1);

        // ---- misaligned access on a bubble: no pulse ----
        t.nop = 1'b1;
        apply(t);
        tick();
        check("nop_mis_pulse", {31'd0, misalign}, 32'd0);

        // ---- BLT / BLTU with rv1=-1, rv2=1 ----
        t = live_instr(); t.br = 1'b1; t.br_op = BR_BLT; t.rv1 = 32'hFFFF_FFFF; t.rv2 = 32'd1;
        t.pc = 32'h80; t.imm = 32'h20; t.alu_op = ALU_SUB;
        apply(t);
        #1;
        check("blt_redirect", {31'd0, redirect}, 32'd1);
        check("blt_target", redirect_pc, 32'hA0);
        t.br_op = BR_BLTU;
        apply(t);
        #1;
        check("bltu_redirect", {31'd0, redirect}, 32'd0);
        tick();

        // ---- JALR ----
        t = live_instr(); t.jalr = 1'b1; t.rv1 = 32'h203; t.imm = 32'h0; t.pc = 32'h40;
        t.rd = 5'd1; t.rwe = 1'b1;
        apply(t);
        #1;
        check("jalr_redirect", {31'd0, redirect}, 32'd1);
        check("jalr_target", redirect_pc, 32'h202);
        tick();
        check("jalr_link", reg_wdata_out, 32'h44);

        // ---- JAL marked as bubble: no redirect ----
        t = live_instr(); t.jal = 1'b1; t.nop = 1'b1; t.pc = 32'h40; t.imm = 32'h8;
        apply(t);
        #1;
        check("nop_jal_redirect", {31'd0, redirect}, 32'd0);
        tick();

        // ---- SW then stall for 3 cycles, then reset during stall ----
        t = live_instr(); t.st = 1'b1; t.sub_op = SUB_SW; t.rv1 = 32'h200; t.imm = 32'd4;
        t.rv2 = 32'hDEAD_BEEF; t.alu_op = ALU_ADD; t.use_imm = 1'b1;
        apply(t);
        tick();
        check("sw_store", {31'd0, is_store_out}, 32'd1);
        check("sw_daddr", daddr, 32'h204);
        stall_in = 1'b1;
        t = live_instr(); t.jal = 1'b1; t.pc = 32'h300; t.imm = 32'h10; t.rd = 5'd9; t.rwe = 1'b1;
        apply(t);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d_redirect", i), {31'd0, redirect}, 32'd0);
            tick();
            check($sformatf("stall%0d_daddr", i), daddr, 32'h204);
            check($sformatf("stall%0d_rv2", i), r_rv2_out, 32'hDEAD_BEEF);
            check($sformatf("stall%0d_flags", i), {28'd0, is_store_out, is_load_out, rwe_out, is_nop_out}, 32'b1000);
        end
        reset = 1'b1;
        tick();
        check("stall_reset_nop", {31'd0, is_nop_out}, 32'd1);
        check("stall_reset_store", {31'd0, is_store_out}, 32'd0);
        check("stall_reset_daddr", daddr, 32'h0);
        check("stall_reset_rv2", r_rv2_out, 32'h0);
        reset = 1'b0; stall_in = 1'b0;
        apply(idle_instr());
        tick();

`ifdef EX_FWD_EN
        // ---- forwarding priority: MEM over WB ----
        t = live_instr(); t.alu_op = ALU_ADD; t.rd = 5'd5; t.rwe = 1'b1; t.use_imm = 1'b1;
        apply(t);
        tick();
        t = live_instr(); t.alu_op = ALU_ADD; t.rs1 = 5'd5; t.rv1 = 32'h11; t.imm = 32'h0;
        t.use_imm = 1'b1; t.rd = 5'd7; t.rwe = 1'b1;
        mem_fwd_rwe = 1'b1; mem_fwd_data = 32'hAA; wb_rd = 5'd5; wb_rwe = 1'b1; wb_data = 32'hBB;
        apply(t);
        tick();
        check("fwd_mem", reg_wdata_out, 32'hAA);
        apply(t);
        tick();
        check("fwd_wb", reg_wdata_out, 32'hBB);
        mem_fwd_rwe = 1'b0; wb_rwe = 1'b0;
`endif

        // ---- random instructions against the model ----
        reset = 1'b1;
        apply(idle_instr());
        tick();
        reset = 1'b0;
        q = reset_exp();
        for (int n = 0; n < 400; n++) begin
            t = live_instr();
            t.pc  = $urandom & 32'hFFFF_FFFC;
            t.rv1 = $urandom;
            t.rv2 = $urandom;
            t.imm = $urandom;
            t.rd  = 5'($urandom_range(0, 31));
            t.rs1 = 5'($urandom_range(0, 31));
            t.rs2 = 5'($urandom_range(0, 31));
            kind  = $urandom_range(0, 5);
            case (kind)
                0, 1: begin
                    t.alu_op  = 4'($urandom_range(0, 11));
                    t.use_imm = 1'($urandom_range(0, 1));
                    if (t.alu_op >= 4'd10) t.use_imm = 1'b1;
                    t.rwe = 1'b1;
                end
                2: begin
                    t.br = 1'b1; t.br_op = 3'($urandom_range(0, 7)); t.alu_op = ALU_SUB;
                    if ($urandom_range(0, 3) == 0) t.rv2 = t.rv1;
                end
                3: begin t.jal = 1'b1; t.rwe = 1'b1; end
                4: begin t.jalr = 1'b1; t.rwe = 1'b1; end
                default: begin
                    t.alu_op = ALU_ADD; t.use_imm = 1'b1;
                    t.imm = 32'($urandom_range(0, 63)) - 32'd32;
                    if ($urandom_range(0, 1) == 1) begin
                        t.ld = 1'b1; t.rwe = 1'b1; t.sub_op = 3'($urandom_range(0, 4));
                    end else begin
                        t.st = 1'b1; t.sub_op = 3'($urandom_range(5, 7));
                    end
                end
            endcase
            t.nop = ($urandom_range(0, 9) == 0);
            stl   = ($urandom_range(0, 7) == 0);
`ifndef EX_FWD_EN
            mem_fwd_data = $urandom; mem_fwd_rwe = 1'($urandom_range(0, 1));
            wb_data = $urandom; wb_rd = 5'($urandom_range(0, 31)); wb_rwe = 1'($urandom_range(0, 1));
`endif
            e = model(t);
            apply(t);
            stall_in = stl;
            #1;
            check($sformatf("r%0d_redirect", n), {31'd0, redirect}, {31'd0, e.redirect && !stl});
            if (e.redirect && !stl)
                check($sformatf("r%0d_target", n), redirect_pc, e.rpc);
            tick();
            if (stl) q.mis = 1'b0;
            else     q = e;
            check($sformatf("r%0d_ctl", n),
                  {25'd0, rd_out, rwe_out, is_load_out},
                  {25'd0, q.rd, q.rwe, q.ld});
            check($sformatf("r%0d_flags", n),
                  {29'd0, is_store_out, is_nop_out, misalign},
                  {29'd0, q.st, q.nop, q.mis});
            if (!q.nop) begin
                check($sformatf("r%0d_wdata", n), reg_wdata_out, q.wdata);
                check($sformatf("r%0d_daddr", n), daddr, q.daddr);
                check($sformatf("r%0d_rv2", n), r_rv2_out, q.rv2);
                check($sformatf("r%0d_subop", n), {29'd0, sub_op_out}, {29'd0, q.sub_op});
            end
        end
        stall_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
